// File: rtl/mult_div_unit.sv
// Multiply/divide unit: architectural HI/LO plus a multi-cycle busy timer and a hazard stall request.
// Optional macro MND_CANCEL_EN adds the Cancel flush input.
//
// state | meaning
// IDLE  | no operation in flight; accepts start and mthi/mtlo writes
// BUSY  | result latched in resHi/resLo, counting down to commit
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  MnDOp,
    input  logic        MnDStart,
    input  logic        MnDWe,
    input  logic        MnDHiLo,
    input  logic        MnDMove,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MND_CANCEL_EN
    input  logic        Cancel,
`endif
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        MnDStall
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      stateQ, stateD;
    logic [4:0]  cntQ, cntD;
    logic [31:0] resHi, resLo;
    logic [31:0] calcHi, calcLo;
    logic        cancel;
    logic        loadRes, commit, writeHi, writeLo;

`ifdef MND_CANCEL_EN
    assign cancel = Cancel;
`else
    assign cancel = 1'b0;
`endif

    logic [63:0] prodS, prodU;
    logic        signedDiv, negQ, negR;
    logic [31:0] divA, divB, divBSafe, quo, rem;

    assign prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prodU = {32'd0, A} * {32'd0, B};

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign signedDiv = MnDOp[0];
    assign divA      = (signedDiv && A[31]) ? (~A + 32'd1) : A;
    assign divB      = (signedDiv && B[31]) ? (~B + 32'd1) : B;
    assign divBSafe  = (B == 32'd0) ? 32'd1 : divB;
    assign quo       = divA / divBSafe;
    assign rem       = divA % divBSafe;
    assign negQ      = signedDiv & (A[31] ^ B[31]);
    assign negR      = signedDiv & A[31];

    always_comb begin
        calcHi = 32'd0;
        calcLo = 32'd0;
        case (MnDOp)
            2'b00: {calcHi, calcLo} = prodU;
            2'b01: {calcHi, calcLo} = prodS;
            default: begin
                if (B == 32'd0) begin
                    calcHi = A;
                    calcLo = 32'hFFFF_FFFF;
                end else begin
                    calcLo = negQ ? (~quo + 32'd1) : quo;
                    calcHi = negR ? (~rem + 32'd1) : rem;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= IDLE;
            cntQ   <= 5'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        case (stateQ)
            IDLE: begin
                if (!cancel && MnDStart) begin
                    stateD = BUSY;
                    cntD   = MnDOp[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                end
            end
            BUSY: begin
                if (cancel) begin
                    stateD = IDLE;
                    cntD   = 5'd0;
                end else begin
                    cntD = cntQ - 5'd1;
                    if (cntQ == 5'd1) stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
                cntD   = 5'd0;
            end
        endcase
    end

    always_comb begin
        Busy     = (stateQ == BUSY);
        MnDStall = Busy & (MnDStart | MnDWe | MnDMove);
        loadRes  = (stateQ == IDLE) & ~cancel & MnDStart;
        commit   = (stateQ == BUSY) & ~cancel & (cntQ == 5'd1);
        writeHi  = (stateQ == IDLE) & ~cancel & ~MnDStart & MnDWe & MnDHiLo;
        writeLo  = (stateQ == IDLE) & ~cancel & ~MnDStart & MnDWe & ~MnDHiLo;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HI    <= 32'd0;
            LO    <= 32'd0;
            resHi <= 32'd0;
            resLo <= 32'd0;
        end else begin
            if (loadRes) begin
                resHi <= calcHi;
                resLo <= calcLo;
            end
            if (commit) begin
                HI <= resHi;
                LO <= resLo;
            end else begin
                if (writeHi) HI <= A;
                if (writeLo) LO <= A;
            end
        end
    end

endmodule
